// File: rtl/irq_pkg.sv
// Shared sizing for the interrupt front end: request-line count, ack index
// width and the miss-counter width with its saturation value.
package irq_pkg;
    localparam int IRQ_N     = 4;
    localparam int IRQ_IDX_W = 2;
    localparam int IRQ_CNT_W = 2;

    localparam logic [IRQ_CNT_W-1:0] IRQ_MISS_MAX = {IRQ_CNT_W{1'b1}};
endpackage : irq_pkg

// File: rtl/irq_pending_latch_if.sv
// Request/ack/pending bus between the request source and the pending latch.
interface irq_pending_latch_if #(
    parameter int N     = irq_pkg::IRQ_N,
    parameter int IDX_W = irq_pkg::IRQ_IDX_W
);
    logic [N-1:0]     req_in;
    logic [N-1:0]     mask;
    logic             ack_valid;
    logic [IDX_W-1:0] ack_idx;
    logic             clear_all;
    logic [N-1:0]     pend_out;
    logic             any_pend;
    logic [N-1:0]     overflow;
    logic             ack_err;

    modport master (
        output req_in, mask, ack_valid, ack_idx, clear_all,
        input  pend_out, any_pend, overflow, ack_err
    );

    modport slave (
        input  req_in, mask, ack_valid, ack_idx, clear_all,
        output pend_out, any_pend, overflow, ack_err
    );
endinterface : irq_pending_latch_if

// File: rtl/rise_detect.sv
// Single-line registered rising-edge detector; the history resets high so a
// line already asserted when reset releases does not count as a new edge.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic prev_r;

    // Previous-sample history register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= d;
        end
    end

    assign rise = d & ~prev_r;
endmodule : rise_detect

// File: rtl/irq_pending_latch.sv
// Sticky, maskable interrupt pending bits with per-line missed-request
// counters and an indexed acknowledge that reports acks to idle lines.
module irq_pending_latch #(
    parameter int N     = irq_pkg::IRQ_N,
    parameter int IDX_W = irq_pkg::IRQ_IDX_W,
    parameter int CNT_W = irq_pkg::IRQ_CNT_W
) (
    input logic               clk,
    input logic               rst_n,
    irq_pending_latch_if.slave bus
);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    logic [N-1:0]     rise_s;
    logic [N-1:0]     ack_sel_s;
    logic [N-1:0]     pending_r;
    logic [N-1:0]     pending_nxt_s;
    logic [CNT_W-1:0] miss_cnt_r     [N];
    logic [CNT_W-1:0] miss_cnt_nxt_s [N];
    logic             ack_err_r;
    logic             ack_err_nxt_s;
    logic [N-1:0]     overflow_s;

    for (genvar g = 0; g < N; g++) begin : g_rise
        rise_detect u_rise (
            .clk   (clk),
            .rst_n (rst_n),
            .d     (bus.req_in[g]),
            .rise  (rise_s[g])
        );
    end

    // One-hot decode of the ack index; an out-of-range index selects nothing
    always_comb begin
        ack_sel_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            ack_sel_s[i] = bus.ack_valid && (bus.ack_idx == IDX_W'(i));
        end
    end

    // Next-state for pending bits and miss counters: clear_all > set > ack
    always_comb begin
        pending_nxt_s = pending_r;
        for (int i = 0; i < N; i++) begin
            miss_cnt_nxt_s[i] = miss_cnt_r[i];
            if (bus.clear_all) begin
                pending_nxt_s[i]  = 1'b0;
                miss_cnt_nxt_s[i] = CNT_ZERO;
            end else if (rise_s[i]) begin
                pending_nxt_s[i] = 1'b1;
                if (ack_sel_s[i]) begin
                    miss_cnt_nxt_s[i] = CNT_ZERO;
                end else if (pending_r[i] && (miss_cnt_r[i] != CNT_MAX)) begin
                    miss_cnt_nxt_s[i] = miss_cnt_r[i] + CNT_W'(1);
                end else begin
                    miss_cnt_nxt_s[i] = miss_cnt_r[i];
                end
            end else if (ack_sel_s[i] && pending_r[i]) begin
                pending_nxt_s[i]  = 1'b0;
                miss_cnt_nxt_s[i] = CNT_ZERO;
            end else begin
                miss_cnt_nxt_s[i] = miss_cnt_r[i];
            end
        end
    end

    // A coincident rise on the acked line makes the ack legitimate
    always_comb begin
        if (bus.ack_valid && !bus.clear_all) begin
            ack_err_nxt_s = ~|(ack_sel_s & (pending_r | rise_s));
        end else begin
            ack_err_nxt_s = 1'b0;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending_r  <= {N{1'b0}};
            miss_cnt_r <= '{default: CNT_ZERO};
            ack_err_r  <= 1'b0;
        end else begin
            pending_r  <= pending_nxt_s;
            miss_cnt_r <= miss_cnt_nxt_s;
            ack_err_r  <= ack_err_nxt_s;
        end
    end

    // Saturation flags
    always_comb begin
        overflow_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            overflow_s[i] = (miss_cnt_r[i] == CNT_MAX);
        end
    end

    assign bus.pend_out = pending_r & ~bus.mask;
    assign bus.any_pend = |(pending_r & ~bus.mask);
    assign bus.overflow = overflow_s;
    assign bus.ack_err  = ack_err_r;
endmodule : irq_pending_latch

// File: tb/tb_irq_pending_latch.sv
// Directed-vector bench for irq_pending_latch with hand-computed expectations.
module tb_irq_pending_latch;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    irq_pending_latch_if #(.N(4), .IDX_W(2)) bus ();

    irq_pending_latch #(.N(4), .IDX_W(2), .CNT_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ack(input logic [1:0] idx);
        bus.ack_valid = 1'b1;
        bus.ack_idx   = idx;
        step();
        bus.ack_valid = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_in    = 4'b0100;
        bus.mask      = 4'b0000;
        bus.ack_valid = 1'b0;
        bus.ack_idx   = 2'd0;
        bus.clear_all = 1'b0;
        step();
        step();
        chk("rst_pend",  bus.pend_out, 4'b0000);
        chk("rst_any",   {3'b000, bus.any_pend}, 4'b0000);
        chk("rst_ovf",   bus.overflow, 4'b0000);
        chk("rst_err",   {3'b000, bus.ack_err}, 4'b0000);

        // Line 2 held through reset must not latch
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("held_no_latch", bus.pend_out, 4'b0000);
        end
        bus.req_in = 4'b0000; step();
        bus.req_in = 4'b0100; step();
        chk("rerise_pend", bus.pend_out, 4'b0100);
        chk("rerise_any",  {3'b000, bus.any_pend}, 4'b0001);
        bus.req_in = 4'b0000;
        ack(2'd2);
        chk("ack2_clear", bus.pend_out, 4'b0000);

        bus.req_in = 4'b1001; step();
        chk("pulse03", bus.pend_out, 4'b1001);
        bus.req_in = 4'b0000;
        ack(2'd3);
        chk("ack3", bus.pend_out, 4'b0001);
        ack(2'd0);
        chk("ack0",     bus.pend_out, 4'b0000);
        chk("ack0_any", {3'b000, bus.any_pend}, 4'b0000);
        chk("ack0_err", {3'b000, bus.ack_err}, 4'b0000);

        // Miss counter on line 1: 1, 2, 3, saturate at 3
        bus.req_in = 4'b0010; step();
        for (int k = 1; k <= 4; k++) begin
            bus.req_in = 4'b0000; step();
            bus.req_in = 4'b0010; step();
            chk($sformatf("miss%0d_ovf", k), bus.overflow, (k >= 3) ? 4'b0010 : 4'b0000);
        end
        chk("miss_pend", bus.pend_out, 4'b0010);
        bus.req_in = 4'b0000;
        ack(2'd1);
        chk("ack1_ovf",  bus.overflow, 4'b0000);
        chk("ack1_pend", bus.pend_out, 4'b0000);

        // Masked lines latch but stay hidden; ack ignores the mask
        bus.mask   = 4'b1111;
        bus.req_in = 4'b1111; step();
        chk("mask_pend", bus.pend_out, 4'b0000);
        chk("mask_any",  {3'b000, bus.any_pend}, 4'b0000);
        bus.req_in = 4'b0000;
        ack(2'd0);
        chk("mask_ack_err", {3'b000, bus.ack_err}, 4'b0000);
        bus.mask = 4'b0000; #1;
        chk("unmask_pend", bus.pend_out, 4'b1110);
        chk("unmask_any",  {3'b000, bus.any_pend}, 4'b0001);
        bus.clear_all = 1'b1; step();
        bus.clear_all = 1'b0;
        chk("flush", bus.pend_out, 4'b0000);

        // Bad acks: single pulse, back-to-back pulses, no state change
        ack(2'd2);
        chk("bad_err",  {3'b000, bus.ack_err}, 4'b0001);
        chk("bad_pend", bus.pend_out, 4'b0000);
        step();
        chk("bad_err_drop", {3'b000, bus.ack_err}, 4'b0000);
        bus.ack_valid = 1'b1; bus.ack_idx = 2'd2; step();
        chk("b2b_err1", {3'b000, bus.ack_err}, 4'b0001);
        step();
        chk("b2b_err2", {3'b000, bus.ack_err}, 4'b0001);
        bus.req_in = 4'b0100; step();
        bus.ack_valid = 1'b0;
        chk("setwins_pend", bus.pend_out, 4'b0100);
        chk("setwins_err",  {3'b000, bus.ack_err}, 4'b0000);
        bus.req_in = 4'b0000;
        ack(2'd2);
        chk("setwins_cleared", bus.pend_out, 4'b0000);

        // clear_all beats a same-cycle rise and ack
        bus.req_in = 4'b1011; step();
        chk("pend1011", bus.pend_out, 4'b1011);
        bus.req_in    = 4'b1111;
        bus.clear_all = 1'b1;
        bus.ack_valid = 1'b1;
        bus.ack_idx   = 2'd2;
        step();
        bus.clear_all = 1'b0;
        bus.ack_valid = 1'b0;
        chk("clr_pend", bus.pend_out, 4'b0000);
        chk("clr_ovf",  bus.overflow, 4'b0000);
        step();
        chk("clr_err",      {3'b000, bus.ack_err}, 4'b0000);
        chk("clr_rise_dropped", bus.pend_out, 4'b0000);

        // Reset mid-operation with lines held high
        bus.req_in = 4'b0000; step();
        bus.req_in = 4'b0110; step();
        chk("pend0110", bus.pend_out, 4'b0110);
        bus.req_in = 4'b1111;
        rst_n = 1'b0; step();
        chk("mrst_pend", bus.pend_out, 4'b0000);
        chk("mrst_any",  {3'b000, bus.any_pend}, 4'b0000);
        chk("mrst_ovf",  bus.overflow, 4'b0000);
        rst_n = 1'b1; step();
        chk("mrst_prev_ones", bus.pend_out, 4'b0000);
        bus.req_in = 4'b0000; step();
        bus.req_in = 4'b1000; step();
        chk("post_rst_rise", bus.pend_out, 4'b1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule : tb_irq_pending_latch

// File: doc/irq_pending_latch.md
Name: irq_pending_latch

Overview:
- Upstream stage of the 4-input priority encoder.
- Converts raw level request lines into sticky, maskable pending bits that drive the encoder's `in` bus directly.
- Tracks requests lost while a line is already pending.
- Accepts an acknowledge that carries the encoded index (the encoder's `out`) back, so the serviced line clears.

Parameters:
- N, 4: number of request lines; must match the encoder input width.
- IDX_W, 2: acknowledge index width, equal to clog2(N).
- CNT_W, 2: width of the per-line missed-request saturating counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_in  input  N  raw level request lines; synchronous to clk.
- mask  input  N  1 = line hidden from pend_out; the line still latches.
- ack_valid  input  1  one-cycle acknowledge strobe.
- ack_idx  input  IDX_W  index of the line being acknowledged.
- clear_all  input  1  synchronous flush of all pending bits and counters.
- pend_out  output  N  pending & ~mask; feeds the encoder `in`.
- any_pend  output  1  OR of pend_out; mirrors the encoder `v`.
- overflow  output  N  line i's miss counter is saturated.
- ack_err  output  1  registered pulse: an ack hit a non-pending line.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - pending=0, miss_cnt=0, ack_err=0.
  - req_prev is loaded with all ones.
  - Outputs pend_out=0, any_pend=0, overflow=0, ack_err=0.
- Edge detect: rise[i] = req_in[i] & ~req_prev[i]. req_prev <= req_in every cycle.
  - A line held high through reset does not latch. It must fall and rise again.
- Set: on a clk edge with rise[i]=1, pending[i] <= 1. pend_out is visible after that edge, so latency is 1 cycle from the sampled rising edge.
- Miss count: when rise[i]=1 and pending[i] is already 1, miss_cnt[i] increments and saturates at 2^CNT_W-1.
  - overflow[i] = (miss_cnt[i] == max); it is combinational from registers.
- Acknowledge: when ack_valid=1 and pending[ack_idx]=1, pending[ack_idx] and miss_cnt[ack_idx] clear at that edge.
- Ack on a non-pending line:
  - Masked lines count as pending; the mask is ignored for ack.
  - No state change; ack_err=1 for exactly the next cycle.
  - ack_idx >= N is treated as an error the same way.
- Simultaneous rise[i] and ack of line i: set wins.
  - pending[i] stays 1; miss_cnt[i] is cleared, not incremented.
  - No ack_err.
- clear_all=1: pending=0, miss_cnt=0.
  - Rises in the same cycle are dropped; req_prev still updates.
  - clear_all has priority over ack_valid; no ack_err is generated.
- Precedence: rst_n > clear_all > set > ack-clear.
- mask affects only pend_out/any_pend. Unmasking a latched line exposes it on the same cycle (combinational).
- ack_err is high only for the single cycle after the offending edge. Back-to-back bad acks give back-to-back pulses.

Decomposition:
- Shared package `irq_pkg`: N, IDX_W, CNT_W defaults and the miss-counter max constant. The encoder uses the same N.
- One natural sub-module: `rise_detect`, a per-line registered edge detector with reset value 1, instantiated N times via generate.
- Pending bits, counters and ack logic stay in the top module.

Test Plan:
- Reset release with req_in=4'b0100 held high -> pend_out=0000 for 3 cycles. Drop and re-raise bit 2 -> pend_out=0100 one cycle after the rising sample; any_pend=1.
- Pulse req_in bits 0 and 3 on the same cycle -> pend_out=1001. ack_valid with ack_idx=3 -> pend_out=0001 next cycle. ack_idx=0 -> pend_out=0000, any_pend=0.
- With pending[1]=1, pulse req_in[1] 4 more times -> miss_cnt saturates at 3 and overflow=0010. Ack idx 1 -> overflow=0000, pend_out=0000.
- mask=1111 and pulse all lines -> pend_out=0000, any_pend=0. Set mask=0000 -> pend_out=1111 the same cycle.
- ack_idx=2 with pending[2]=0 -> ack_err=1 for exactly one cycle, pending unchanged. Rise on line 2 plus ack idx 2 in the same cycle -> pend_out[2]=1, ack_err=0.
- Mid-operation: with pending=1011, assert clear_all -> pend_out=0000. Then, with pending=0110, drive rst_n=0 for one cycle -> all outputs 0 and req_prev=1111.
